fft_output_reorder: RTL and testbench
=====================================

FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the width of one complex sample word ({re, im}, 16+16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an input beat (two samples) is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an input beat.
REQ-006 The block SHALL have port in_data0, input, DW bits: lane 0 sample (bank 0 read data from the last FFT stage).
REQ-007 The block SHALL have port in_data1, input, DW bits: lane 1 sample (bank 1 read data).
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid natural-order sample.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-010 The block SHALL have port out_data, output, DW bits: output sample in natural order.
REQ-011 The block SHALL have port out_idx, output, 6 bits: natural frequency index of out_data.
REQ-012 The block SHALL have port out_last, output, 1 bit: high while out_idx == 63 and out_valid.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last sample of a frame transfers.

Function
REQ-014 The block SHALL accept a beat when in_valid && in_ready on a rising clk edge; otherwise no input state SHALL change.
REQ-015 A frame SHALL be 32 beats (64 points); a 5-bit write counter wr_cnt SHALL count accepted beats 0..31 and wrap to 0.
REQ-016 On beat k, lane 0 SHALL be stored at address bitrev6({k,0}) and lane 1 at address bitrev6({k,1}) of the write buffer, where bitrev6 reverses all 6 bits.
REQ-017 The block SHALL contain two 64 x DW buffers (ping-pong), wr_sel/rd_sel select bits, and a full flag per buffer.
REQ-018 On acceptance of beat 31, full[wr_sel] SHALL be set and wr_sel SHALL toggle in the same edge.
REQ-019 in_ready SHALL equal !full[wr_sel], decoded from registers only, with no combinational path from in_valid.
REQ-020 out_valid SHALL equal full[rd_sel]; out_data SHALL be buf[rd_sel][rd_cnt]; out_idx SHALL be rd_cnt (6-bit read counter).
REQ-021 On out_valid && out_ready, rd_cnt SHALL increment; on the transfer with rd_cnt == 63, rd_cnt SHALL wrap to 0, full[rd_sel] SHALL clear, rd_sel SHALL toggle, and frame_done SHALL be 1 in the following cycle only.
REQ-022 While out_valid && !out_ready, out_data, out_idx and out_last SHALL hold stable.
REQ-023 Latency: out_valid SHALL rise the cycle after beat 31 is accepted, if rd_sel points to that buffer.
REQ-024 Simultaneous frame-write completion and frame-read completion on opposite buffers in one edge SHALL both take effect.
REQ-025 With both buffers full, in_ready SHALL be 0; it SHALL return to 1 the cycle after the read frame completes.
REQ-026 With out_ready held at 1 and frames supplied back-to-back, output SHALL be gapless at one sample per cycle.

Reset
REQ-027 While rst is high: wr_cnt = 0, rd_cnt = 0, wr_sel = 0, rd_sel = 0, full = 2'b00, out_valid = 0, frame_done = 0, in_ready = 1; buffer contents are not reset.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the next accepted beat SHALL be beat 0.

Verification
REQ-029 Release rst -> in_ready = 1, out_valid = 0, frame_done = 0.
REQ-030 One frame with lane0 = bitrev6(2k), lane1 = bitrev6(2k+1) (beat 0: 0/32; beat 1: 16/48), out_ready = 1 -> out_data = 0..63 on consecutive cycles, out_idx = out_data, out_last at 63, frame_done the next cycle.
REQ-031 out_ready = 0, three frames offered -> two frames accepted, in_ready = 0 at beat 0 of frame 3, out_data = 0 held stable.
REQ-032 Four back-to-back frames with out_ready = 1 -> 256 output samples with no bubble after the first out_valid.
REQ-033 rst pulsed after beat 10 -> in_ready = 1, out_valid = 0; the following full frame outputs 0..63 correctly.
REQ-034 Frame B beat 31 accepted in the same cycle frame A idx 63 transfers -> full toggles correctly, the next cycle outputs B idx 0, and frame_done = 1.

Source files
------------

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: converts two-lane bit-reversed FFT output beats
// into a natural-order sample stream with index, last and frame-done markers.
module fft_output_reorder #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data0,
    input  logic [DW-1:0] in_data1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [5:0]    out_idx,
    output logic          out_last,
    output logic          frame_done
);

    localparam int unsigned NPTS  = 64;
    localparam int unsigned BEATS = 32;
    localparam int unsigned AW    = 6;
    localparam int unsigned BW    = 5;

    logic [BW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [1:0]    full_q,   full_d;
    logic          frame_done_q, frame_done_d;

    logic [DW-1:0] buf0_q [NPTS];
    logic [DW-1:0] buf1_q [NPTS];

    logic          in_fire;
    logic          out_fire;
    logic [AW-1:0] wr_addr0;
    logic [AW-1:0] wr_addr1;

    function automatic logic [AW-1:0] bitrev6(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < int'(AW); i++) begin
            r[i] = a[int'(AW) - 1 - i];
        end
        return r;
    endfunction

    // Handshake decode and read-side datapath, all from registered state
    always_comb begin
        in_ready   = !full_q[wr_sel_q];
        out_valid  = full_q[rd_sel_q];
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        wr_addr0   = bitrev6({wr_cnt_q, 1'b0});
        wr_addr1   = bitrev6({wr_cnt_q, 1'b1});
        out_data   = rd_sel_q ? buf1_q[rd_cnt_q] : buf0_q[rd_cnt_q];
        out_idx    = rd_cnt_q;
        out_last   = out_valid && (rd_cnt_q == AW'(NPTS - 1));
        frame_done = frame_done_q;
    end

    // Next-state for counters, bank selects and full flags
    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        full_d       = full_q;
        frame_done_d = 1'b0;

        if (in_fire) begin
            wr_cnt_d = wr_cnt_q + BW'(1);
            if (wr_cnt_q == BW'(BEATS - 1)) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
            end
        end

        // Read completion frees the other bank; it never collides with the write bank
        if (out_fire) begin
            rd_cnt_d = rd_cnt_q + AW'(1);
            if (rd_cnt_q == AW'(NPTS - 1)) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
                frame_done_d     = 1'b1;
            end
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            full_q       <= 2'b00;
            frame_done_q <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            full_q       <= full_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Sample storage, scattered to natural-order addresses; contents not reset
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (wr_sel_q) begin
                buf1_q[wr_addr0] <= in_data0;
                buf1_q[wr_addr1] <= in_data1;
            end else begin
                buf0_q[wr_addr0] <= in_data0;
                buf0_q[wr_addr1] <= in_data1;
            end
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder: expected natural-order samples are
// queued as beats are accepted and popped as the DUT transfers output.
module tb_fft_output_reorder;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data0;
    logic [DW-1:0] in_data1;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [5:0]    out_idx;
    logic          out_last;
    logic          frame_done;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [5:0]    idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    logic fd_exp = 1'b0;

    fft_output_reorder #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data0   (in_data0),
        .in_data1   (in_data1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] brev(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[5 - i] = a[i];
        return r;
    endfunction

    // Output monitor: pops the scoreboard on each transfer and tracks frame_done
    always @(negedge clk) begin
        if (rst) begin
            fd_exp = 1'b0;
        end else begin
            checks++;
            if (frame_done !== fd_exp) begin
                errors++;
                $display("FAIL frame_done: got %b required %b at %0t", frame_done, fd_exp, $time);
            end
            fd_exp = (out_valid === 1'b1) && (out_ready === 1'b1) && (out_idx === 6'd63);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got idx %0d data %h, required no output at %0t",
                             out_idx, out_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_data !== mon_e.data || out_idx !== mon_e.idx ||
                        out_last !== (mon_e.idx == 6'd63)) begin
                        errors++;
                        $display("FAIL out_sample: got data %h idx %0d last %b, required data %h idx %0d last %b at %0t",
                                 out_data, out_idx, out_last, mon_e.data, mon_e.idx,
                                 (mon_e.idx == 6'd63), $time);
                    end
                end
            end
        end
    end

    // Drives nbeats beats of a tagged frame; queues the natural-order image once complete
    task automatic send_frame(input logic [25:0] tag, input int nbeats);
        logic [DW-1:0] img [64];
        for (int k = 0; k < nbeats; k++) begin
            int n;
            in_valid = 1'b1;
            in_data0 = {tag, brev(6'(2 * k))};
            in_data1 = {tag, brev(6'(2 * k + 1))};
            n = 0;
            @(negedge clk);
            while (in_ready !== 1'b1 && n < 2000) begin
                n++;
                @(negedge clk);
            end
            if (in_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL in_accept_timeout: beat %0d in_ready %b, required 1", k, in_ready);
                in_valid = 1'b0;
                return;
            end
            img[brev(6'(2 * k))]     = in_data0;
            img[brev(6'(2 * k + 1))] = in_data1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (nbeats == 32) begin
            for (int i = 0; i < 64; i++) exp_q.push_back('{data: img[i], idx: 6'(i)});
        end
    endtask

    // Waits for the scoreboard to empty, then realigns to just after a rising edge
    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d samples pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data0 = '0; in_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got in_ready %b out_valid %b frame_done %b, required 1 0 0",
                     in_ready, out_valid, frame_done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready %b out_valid %b frame_done %b, required 1 0 0",
                     in_ready, out_valid, frame_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame;
        int n0;
        n0 = n_out;
        out_ready = 1'b1;
        send_frame(26'h1, 32);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 6'd0) begin
            errors++;
            $display("FAIL first_latency: got out_valid %b idx %0d, required 1 0", out_valid, out_idx);
        end
        wait_drain(200);
        checks++;
        if (n_out - n0 != 64 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_frame_end: got %0d samples out_valid %b in_ready %b, required 64 0 1",
                     n_out - n0, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure;
        bit found;
        int n;
        out_ready = 1'b0;
        send_frame(26'h2, 32);
        send_frame(26'h3, 32);
        in_valid = 1'b1;
        in_data0 = {26'h4, brev(6'd0)};
        in_data1 = {26'h4, brev(6'd1)};
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== {26'h2, 6'd0} ||
                out_idx !== 6'd0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got in_ready %b out_valid %b data %h idx %0d last %b, required 0 1 %h 0 0",
                         in_ready, out_valid, out_data, out_idx, out_last, {26'h2, 6'd0});
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1 && out_idx === 6'd63) begin
                found = 1'b1;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL both_full_ready: got in_ready %b, required 0", in_ready);
                end
                @(negedge clk);
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_free: got in_ready %b, required 1", in_ready);
                end
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL bp_last_timeout: got no idx 63 transfer, required one");
        end
        wait_drain(300);
    endtask

    task automatic test_back_to_back;
        int n0;
        int bubbles;
        int n;
        n0 = n_out;
        bubbles = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int f = 0; f < 4; f++) send_frame(26'h10 + 26'(f), 32);
            end
            begin
                n = 0;
                @(negedge clk);
                while (out_valid !== 1'b1 && n < 200) begin
                    n++;
                    @(negedge clk);
                end
                for (int i = 0; i < 256; i++) begin
                    if (out_valid !== 1'b1) bubbles++;
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (bubbles != 0) begin
            errors++;
            $display("FAIL b2b_bubbles: got %0d idle cycles, required 0", bubbles);
        end
        wait_drain(400);
        checks++;
        if (n_out - n0 != 256) begin
            errors++;
            $display("FAIL b2b_count: got %0d samples, required 256", n_out - n0);
        end
    endtask

    task automatic test_mid_reset;
        int n0;
        out_ready = 1'b1;
        send_frame(26'h20, 11);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got in_ready %b out_valid %b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        n0 = n_out;
        send_frame(26'h21, 32);
        wait_drain(200);
        checks++;
        if (n_out - n0 != 64) begin
            errors++;
            $display("FAIL post_reset_count: got %0d samples, required 64", n_out - n0);
        end
    endtask

    task automatic test_simultaneous;
        bit found;
        int n;
        out_ready = 1'b0;
        send_frame(26'h30, 32);
        out_ready = 1'b1;
        fork
            begin
                repeat (32) @(posedge clk);
                #1;
                send_frame(26'h31, 32);
            end
            begin
                found = 1'b0;
                n = 0;
                while (!found && n < 200) begin
                    @(negedge clk);
                    n++;
                    if (out_valid === 1'b1 && out_idx === 6'd63) begin
                        found = 1'b1;
                        checks++;
                        if (in_valid !== 1'b1 || in_ready !== 1'b1 || in_data1 !== {26'h31, 6'd63}) begin
                            errors++;
                            $display("FAIL sim_align: got in_valid %b in_ready %b data1 %h, required 1 1 %h",
                                     in_valid, in_ready, in_data1, {26'h31, 6'd63});
                        end
                        @(negedge clk);
                        checks++;
                        if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_data !== {26'h31, 6'd0} ||
                            frame_done !== 1'b1 || in_ready !== 1'b1) begin
                            errors++;
                            $display("FAIL sim_swap: got valid %b idx %0d data %h done %b in_ready %b, required 1 0 %h 1 1",
                                     out_valid, out_idx, out_data, frame_done, in_ready, {26'h31, 6'd0});
                        end
                    end
                end
                if (!found) begin
                    checks++;
                    errors++;
                    $display("FAIL sim_timeout: got no idx 63 transfer, required one");
                end
            end
        join
        wait_drain(200);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data0 = '0; in_data1 = '0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
